// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: front-end PC / IF-ID / ID-EX sequencing for load-use, taken-branch and memory-wait events.
// Define HAZARD_STATS_EN to build the saturating stall/flush statistics counters.
module pipeline_hazard_ctrl #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES      = 1,
    parameter int STAT_W            = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [3:0]        id_rs1,
    input  logic [3:0]        id_rs2,
    input  logic              id_uses_rs2,
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic [3:0]        ex_rd,
    input  logic              ex_branch_taken,
    input  logic              mem_busy,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              if_id_flush,
    output logic              id_ex_bubble,
    output logic              ex_en,
    output logic [STAT_W-1:0] stall_cycles,
    output logic [STAT_W-1:0] flush_events
);
    typedef enum logic [1:0] {RUN, LOAD_STALL, FLUSH, MEM_WAIT} state_t;

    // {pc_en, if_id_en, if_id_flush, id_ex_bubble, ex_en}
    localparam logic [4:0] RUN_SET    = 5'b11001;
    localparam logic [4:0] STALL_SET  = 5'b00011;
    localparam logic [4:0] FLUSH_SET  = 5'b11111;
    localparam logic [4:0] FREEZE_SET = 5'b00000;
    localparam logic [4:0] RESET_SET  = 5'b00110;
    localparam logic [3:0] LS_INIT    = 4'(LOAD_STALL_CYCLES - 1);
    localparam logic [3:0] FL_INIT    = 4'(FLUSH_CYCLES - 1);

    state_t     r_state, r_saved, w_next, w_next_saved, w_cur;
    logic [3:0] r_cnt, r_saved_cnt, w_next_cnt, w_next_saved_cnt, w_cur_cnt, w_dec;
    logic       r_ready;
    logic       w_hazard;
    logic [4:0] w_out;

    assign w_hazard = id_valid & ex_valid & ex_mem_read & (ex_rd != 4'd0) &
                      ((id_rs1 == ex_rd) | (id_uses_rs2 & (id_rs2 == ex_rd)));

    // Leaving MEM_WAIT resumes the saved sequence in the same cycle.
    assign w_cur     = (r_state == MEM_WAIT) ? r_saved : r_state;
    assign w_cur_cnt = (r_state == MEM_WAIT) ? r_saved_cnt : r_cnt;
    assign w_dec     = w_cur_cnt - 4'd1;

    always_comb begin
        w_out            = RESET_SET;
        w_next           = r_state;
        w_next_cnt       = r_cnt;
        w_next_saved     = r_saved;
        w_next_saved_cnt = r_saved_cnt;
        if (!r_ready) begin
            w_out = RESET_SET;
        end else if (mem_busy) begin
            w_out = FREEZE_SET;
            if (r_state != MEM_WAIT) begin
                w_next_saved     = r_state;
                w_next_saved_cnt = r_cnt;
                w_next           = MEM_WAIT;
            end
        end else if (ex_branch_taken) begin
            w_out      = FLUSH_SET;
            w_next     = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
            w_next_cnt = FL_INIT;
        end else if (w_hazard && w_cur == RUN) begin
            w_out      = STALL_SET;
            w_next     = (LOAD_STALL_CYCLES > 1) ? LOAD_STALL : RUN;
            w_next_cnt = LS_INIT;
        end else if (w_cur == LOAD_STALL) begin
            w_out      = STALL_SET;
            w_next     = (w_dec == 4'd0) ? RUN : LOAD_STALL;
            w_next_cnt = w_dec;
        end else if (w_cur == FLUSH) begin
            w_out      = FLUSH_SET;
            w_next     = (w_dec == 4'd0) ? RUN : FLUSH;
            w_next_cnt = w_dec;
        end else begin
            w_out      = RUN_SET;
            w_next     = RUN;
            w_next_cnt = 4'd0;
        end
    end

    assign {pc_en, if_id_en, if_id_flush, id_ex_bubble, ex_en} = w_out;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= RUN;
            r_cnt       <= 4'd0;
            r_saved     <= RUN;
            r_saved_cnt <= 4'd0;
            r_ready     <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_cnt       <= w_next_cnt;
            r_saved     <= w_next_saved;
            r_saved_cnt <= w_next_saved_cnt;
            r_ready     <= 1'b1;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [STAT_W-1:0] r_stall_cnt, r_flush_cnt;
    logic              w_stall_inc, w_flush_inc;

    assign w_stall_inc = r_ready & (w_out == STALL_SET);
    assign w_flush_inc = r_ready & ~mem_busy & ex_branch_taken;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_inc && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_flush_inc && r_flush_cnt != '1)
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign stall_cycles = r_stall_cnt;
    assign flush_events = r_flush_cnt;
`else
    assign stall_cycles = '0;
    assign flush_events = '0;
`endif
endmodule
